// File: rtl/fadd_seq_if.sv
// Signal bundle between the MIX execute unit, the fadd_seq sequencer and the fadd adder.
// The slave modport is the sequencer's view. The master modport is the view of its surroundings.
interface fadd_seq_if;
  logic        go;
  logic [1:0]  op;
  logic [30:0] ra;
  logic [30:0] v;
  logic        busy;
  logic        done;
  logic [30:0] result;
  logic        write_a;
  logic        ovf_set;
  logic        cmp_lt;
  logic        cmp_eq;
  logic        cmp_gt;
  logic        err;
  logic        fa_start;
  logic        fa_sub;
  logic [30:0] fa_in1;
  logic [30:0] fa_in2;
  logic [30:0] fa_out;
  logic        fa_stop;
  logic        fa_overflow;

  modport master (
    output go, op, ra, v, fa_out, fa_stop, fa_overflow,
    input  busy, done, result, write_a, ovf_set, cmp_lt, cmp_eq, cmp_gt, err,
           fa_start, fa_sub, fa_in1, fa_in2
  );

  modport slave (
    input  go, op, ra, v, fa_out, fa_stop, fa_overflow,
    output busy, done, result, write_a, ovf_set, cmp_lt, cmp_eq, cmp_gt, err,
           fa_start, fa_sub, fa_in1, fa_in2
  );
endinterface

// File: rtl/fadd_seq.sv
// Sequences one FADD/FSUB/FCMP request through the fadd unit and returns a one-cycle done
// that carries the result, the overflow-toggle request and the comparison flags.
module fadd_seq #(
  parameter int TMO = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  fadd_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [1:0] OP_FADD  = 2'b00;
  localparam logic [1:0] OP_FSUB  = 2'b01;
  localparam logic [1:0] OP_FCMP  = 2'b10;
  localparam logic [1:0] OP_RSV   = 2'b11;
  localparam logic [3:0] TMO_LAST = 4'(TMO - 1);

  state_t      r_state;
  state_t      w_nextState;
  logic [30:0] r_a;
  logic [30:0] r_b;
  logic [1:0]  r_op;
  logic [30:0] r_result;
  logic [3:0]  r_cnt;
  logic        r_ovf;
  logic        r_errPend;
  logic        r_cmpLt;
  logic        r_cmpEq;
  logic        r_cmpGt;
  logic        w_timeout;
  logic        w_zero;
  logic        w_arith;

  // A stop arriving in the last allowed cycle beats the timeout.
  assign w_timeout = (r_state == WAIT) && !bus.fa_stop && (r_cnt == TMO_LAST);
  assign w_zero    = (bus.fa_out[23:0] == 24'd0);
  assign w_arith   = (r_op == OP_FADD) || (r_op == OP_FSUB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (bus.go) w_nextState = (bus.op == OP_RSV) ? DONE : ISSUE;
      ISSUE:   w_nextState = WAIT;
      WAIT:    if (bus.fa_stop || w_timeout) w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_op      <= OP_FADD;
      r_result  <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      r_errPend <= 1'b0;
      r_cmpLt   <= 1'b0;
      r_cmpEq   <= 1'b0;
      r_cmpGt   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.go) begin
            r_a       <= bus.ra;
            r_b       <= bus.v;
            r_op      <= bus.op;
            r_errPend <= (bus.op == OP_RSV);
            r_ovf     <= 1'b0;
          end
        end
        ISSUE: r_cnt <= '0;
        WAIT: begin
          if (bus.fa_stop) begin
            r_result <= bus.fa_out;
            r_ovf    <= bus.fa_overflow;
            // Exact compare: the sign of the difference decides, overflow does not matter.
            if (r_op == OP_FCMP) begin
              r_cmpEq <= w_zero;
              r_cmpLt <= !w_zero && bus.fa_out[30];
              r_cmpGt <= !w_zero && !bus.fa_out[30];
            end
          end else if (w_timeout) begin
            r_errPend <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.busy     = (r_state != IDLE);
    bus.done     = (r_state == DONE);
    bus.err      = (r_state == DONE) && r_errPend;
    bus.write_a  = (r_state == DONE) && !r_errPend && w_arith;
    bus.ovf_set  = (r_state == DONE) && !r_errPend && w_arith && r_ovf;
    bus.fa_start = (r_state == ISSUE);
    bus.fa_sub   = (r_state != IDLE) && ((r_op == OP_FSUB) || (r_op == OP_FCMP));
    bus.fa_in1   = r_a;
    bus.fa_in2   = r_b;
    bus.result   = r_result;
    bus.cmp_lt   = r_cmpLt;
    bus.cmp_eq   = r_cmpEq;
    bus.cmp_gt   = r_cmpGt;
  end

endmodule

// File: tb/tb_fadd_seq.sv
// Bench for fadd_seq: a behavioural MIX fadd stub with programmable stop latency, a directed
// vector table, a mid-operation reset sequence and randomized requests checked against a model.
module tb_fadd_seq;

  localparam int TMO = 8;

  typedef struct {
    logic [1:0]  op;
    logic [30:0] ra;
    logic [30:0] v;
    int          delay;
    bit          poke;
    int          expLat;
    logic [30:0] expResult;
    bit          expWriteA;
    bit          expOvf;
    bit          expErr;
    logic [2:0]  expFlags;
    int          expStarts;
  } vec_t;

  typedef struct {
    int          lat;
    logic [30:0] result;
    logic        writeA;
    logic        ovf;
    logic        err;
    logic [2:0]  flags;
    int          starts;
    bit          busyGap;
    bit          inMoved;
    logic        doneAfter;
    logic        busyAfter;
  } obs_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   stubDelay;
  int   totalStarts = 0;
  logic [30:0] heldResult;
  logic [2:0]  heldFlags;
  vec_t tbl [11];

  fadd_seq_if bus ();

  fadd_seq #(.TMO(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.fa_start === 1'b1) totalStarts++;
  end

  // Byte-aligned MIX floating add: align by 6-bit bytes, add sign-magnitude, renormalize.
  function automatic void faddModel(input logic [30:0] x, input logic [30:0] y, input logic sub,
                                    output logic [30:0] r, output logic ovf);
    int     ea, eb, e, d, te;
    longint fa, fb, s, tf;
    logic   sa, sb, sr, ts;
    sa = x[30];
    sb = y[30] ^ sub;
    ea = int'(x[29:24]);
    eb = int'(y[29:24]);
    fa = longint'(x[23:0]);
    fb = longint'(y[23:0]);
    if (eb > ea) begin
      ts = sa; sa = sb; sb = ts;
      te = ea; ea = eb; eb = te;
      tf = fa; fa = fb; fb = tf;
    end
    d  = ea - eb;
    fb = (d >= 4) ? 64'd0 : (fb >> (6 * d));
    e  = ea;
    if (sa == sb) begin
      s = fa + fb; sr = sa;
    end else if (fa >= fb) begin
      s = fa - fb; sr = sa;
    end else begin
      s = fb - fa; sr = sb;
    end
    ovf = 1'b0;
    r   = '0;
    if (s != 0) begin
      if (s >= 64'h100_0000) begin
        s = s >> 6;
        e++;
      end
      while (s < 64'h4_0000) begin
        s = s << 6;
        e--;
      end
      ovf = (e > 63) || (e < 0);
      r   = {sr, 6'(e), 24'(s)};
    end
  endfunction

  // fadd stub: samples in1 with start, in2 one cycle later, raises stop stubDelay cycles after start.
  initial begin
    logic [30:0] in1, in2, res;
    logic        sub, ov;
    int          d;
    bus.fa_stop     = 1'b0;
    bus.fa_out      = '0;
    bus.fa_overflow = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bus.fa_start === 1'b1 && stubDelay > 0) begin
        in1 = bus.fa_in1;
        sub = bus.fa_sub;
        d   = stubDelay;
        @(posedge clk); #1;
        in2 = bus.fa_in2;
        for (int k = 1; k < d; k++) begin
          @(posedge clk); #1;
        end
        faddModel(in1, in2, sub, res, ov);
        bus.fa_out      = res;
        bus.fa_overflow = ov;
        bus.fa_stop     = 1'b1;
        @(posedge clk); #1;
        bus.fa_stop     = 1'b0;
        bus.fa_out      = 31'($urandom);
        bus.fa_overflow = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [30:0] ra, input logic [30:0] v,
                               input int delay, input bit poke, output obs_t obs);
    int startBase;
    bit seen;
    stubDelay = delay;
    startBase = totalStarts;
    obs       = '{default: 0};
    seen      = 1'b0;
    bus.go = 1'b1;
    bus.op = op;
    bus.ra = ra;
    bus.v  = v;
    while (!seen && obs.lat < 20) begin
      @(posedge clk); #1;
      obs.lat++;
      bus.go = poke && (obs.lat == 3);
      if (bus.go) begin
        bus.op = 2'b11;
        bus.ra = ~ra;
      end
      if (bus.fa_in1 !== ra || bus.fa_in2 !== v) obs.inMoved = 1'b1;
      if (bus.busy !== 1'b1) obs.busyGap = 1'b1;
      if (bus.done === 1'b1) begin
        seen       = 1'b1;
        obs.result = bus.result;
        obs.writeA = bus.write_a;
        obs.ovf    = bus.ovf_set;
        obs.err    = bus.err;
        obs.flags  = {bus.cmp_lt, bus.cmp_eq, bus.cmp_gt};
      end
    end
    bus.go = 1'b0;
    @(posedge clk); #1;
    obs.doneAfter = bus.done;
    obs.busyAfter = bus.busy;
    obs.starts    = totalStarts - startBase;
  endtask

  task automatic checkOutput(input string tag, input obs_t obs, input vec_t exp);
    checkVal({tag, ".latency"}, 32'(obs.lat), 32'(exp.expLat));
    checkVal({tag, ".result"}, {1'b0, obs.result}, {1'b0, exp.expResult});
    checkVal({tag, ".write_a"}, 32'(obs.writeA), 32'(exp.expWriteA));
    checkVal({tag, ".ovf_set"}, 32'(obs.ovf), 32'(exp.expOvf));
    checkVal({tag, ".err"}, 32'(obs.err), 32'(exp.expErr));
    checkVal({tag, ".cmp_lt_eq_gt"}, 32'(obs.flags), 32'(exp.expFlags));
    checkVal({tag, ".fa_start_count"}, 32'(obs.starts), 32'(exp.expStarts));
    checkVal({tag, ".busy_until_done"}, 32'(obs.busyGap), 32'd0);
    checkVal({tag, ".operands_stable"}, 32'(obs.inMoved), 32'd0);
    checkVal({tag, ".done_one_cycle"}, 32'(obs.doneAfter), 32'd0);
    checkVal({tag, ".idle_after"}, 32'(obs.busyAfter), 32'd0);
  endtask

  task automatic resetMidOp();
    int doneSeen;
    int busySeen;
    stubDelay = 3;
    bus.go = 1'b1;
    bus.op = 2'b00;
    bus.ra = 31'h21040000;
    bus.v  = 31'h21040000;
    @(posedge clk); #1;
    bus.go = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checkVal("rst.controls", 32'({bus.busy, bus.done, bus.write_a, bus.ovf_set, bus.err, bus.cmp_lt,
                                 bus.cmp_eq, bus.cmp_gt, bus.fa_start, bus.fa_sub}), 32'd0);
    checkVal("rst.result", {1'b0, bus.result}, 32'd0);
    checkVal("rst.operands", {1'b0, bus.fa_in1 | bus.fa_in2}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    doneSeen = 0;
    busySeen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) doneSeen++;
      if (bus.busy === 1'b1) busySeen++;
    end
    checkVal("rst.no_done", 32'(doneSeen), 32'd0);
    checkVal("rst.late_stop_ignored", 32'(busySeen), 32'd0);
    heldResult = '0;
    heldFlags  = '0;
  endtask

  task automatic runRandom(input int n);
    vec_t        e;
    obs_t        obs;
    logic [30:0] r;
    logic        ov;
    int          sel;
    int          stopCycle;
    for (int i = 0; i < n; i++) begin
      sel  = int'($urandom_range(0, 9));
      e.op = (sel == 9) ? 2'b11 : 2'(sel % 3);
      e.ra = {1'($urandom_range(0, 1)), 6'($urandom_range(4, 63)), 24'($urandom_range(24'h040000, 24'hFFFFFF))};
      e.v  = {1'($urandom_range(0, 1)), 6'($urandom_range(4, 63)), 24'($urandom_range(24'h040000, 24'hFFFFFF))};
      if ($urandom_range(0, 7) == 0) e.v = e.ra;
      e.delay = int'($urandom_range(0, 9));
      e.poke  = 1'b0;
      ov      = 1'b0;
      stopCycle = 1 + e.delay;
      if (e.op == 2'b11) begin
        e.expLat = 1; e.expErr = 1'b1; e.expStarts = 0;
      end else if (e.delay == 0 || stopCycle > TMO + 1) begin
        e.expLat = TMO + 2; e.expErr = 1'b1; e.expStarts = 1;
      end else begin
        e.expLat = stopCycle + 1; e.expErr = 1'b0; e.expStarts = 1;
        faddModel(e.ra, e.v, e.op != 2'b00, r, ov);
        heldResult = r;
        if (e.op == 2'b10)
          heldFlags = (r[23:0] == 24'd0) ? 3'b010 : (r[30] ? 3'b100 : 3'b001);
      end
      e.expWriteA = !e.expErr && (e.op != 2'b10);
      e.expOvf    = e.expWriteA && ov;
      e.expResult = heldResult;
      e.expFlags  = heldFlags;
      applyStimulus(e.op, e.ra, e.v, e.delay, e.poke, obs);
      checkOutput($sformatf("rand%0d", i), obs, e);
    end
  endtask

  initial begin
    obs_t obs;
    vec_t e;
    checks    = 0;
    failures  = 0;
    clk       = 1'b0;
    rst_n     = 1'b0;
    stubDelay = 3;
    bus.go    = 1'b0;
    bus.op    = 2'b00;
    bus.ra    = '0;
    bus.v     = '0;

    //          op     ra            v             dly poke lat result        wa    ov    err   flags   st
    tbl[0]  = '{2'b00, 31'h21040000, 31'h21040000, 3, 0,  5,  31'h21080000, 1'b1, 1'b0, 1'b0, 3'b000, 1};
    tbl[1]  = '{2'b01, 31'h21040000, 31'h21040000, 3, 0,  5,  31'h00000000, 1'b1, 1'b0, 1'b0, 3'b000, 1};
    tbl[2]  = '{2'b10, 31'h21040000, 31'h21080000, 3, 0,  5,  31'h61040000, 1'b0, 1'b0, 1'b0, 3'b100, 1};
    tbl[3]  = '{2'b00, 31'h3FFC0000, 31'h3FFC0000, 3, 0,  5,  31'h0007E000, 1'b1, 1'b1, 1'b0, 3'b100, 1};
    tbl[4]  = '{2'b10, 31'h3FFC0000, 31'h3FFC0000, 3, 0,  5,  31'h00000000, 1'b0, 1'b0, 1'b0, 3'b010, 1};
    tbl[5]  = '{2'b11, 31'h21040000, 31'h21080000, 3, 0,  1,  31'h00000000, 1'b0, 1'b0, 1'b1, 3'b010, 0};
    tbl[6]  = '{2'b10, 31'h3FFC0000, 31'h7FFC0000, 3, 0,  5,  31'h0007E000, 1'b0, 1'b0, 1'b0, 3'b001, 1};
    tbl[7]  = '{2'b10, 31'h21080000, 31'h21040000, 2, 0,  4,  31'h21040000, 1'b0, 1'b0, 1'b0, 3'b001, 1};
    tbl[8]  = '{2'b00, 31'h21040000, 31'h21040000, 0, 1,  10, 31'h21040000, 1'b0, 1'b0, 1'b1, 3'b001, 1};
    tbl[9]  = '{2'b00, 31'h21040000, 31'h21040000, 8, 0,  10, 31'h21080000, 1'b1, 1'b0, 1'b0, 3'b001, 1};
    tbl[10] = '{2'b01, 31'h21040000, 31'h21080000, 1, 0,  3,  31'h61040000, 1'b1, 1'b0, 1'b0, 3'b001, 1};

    repeat (2) @(posedge clk);
    #1;
    checkVal("reset.busy_done", 32'({bus.busy, bus.done}), 32'd0);
    checkVal("reset.result", {1'b0, bus.result}, 32'd0);
    checkVal("reset.outputs", 32'({bus.write_a, bus.ovf_set, bus.err, bus.cmp_lt, bus.cmp_eq,
                                  bus.cmp_gt, bus.fa_start, bus.fa_sub}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      applyStimulus(tbl[i].op, tbl[i].ra, tbl[i].v, tbl[i].delay, tbl[i].poke, obs);
      checkOutput($sformatf("vec%0d", i), obs, tbl[i]);
    end

    resetMidOp();

    e = '{2'b00, 31'h21040000, 31'h21040000, 3, 0, 5, 31'h21080000, 1'b1, 1'b0, 1'b0, 3'b000, 1};
    applyStimulus(e.op, e.ra, e.v, e.delay, e.poke, obs);
    checkOutput("post_reset", obs, e);
    heldResult = 31'h21080000;
    heldFlags  = 3'b000;

    runRandom(60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
